// File: rtl/debounce_ctrl_pkg.sv
// debounce_ctrl shared constants
// Board default timing at 125 MHz
package debounce_ctrl_pkg;

  localparam int SAMPLE_CNT_MAX_DEF = 62500;
  localparam int PULSE_CNT_MAX_DEF  = 200;

endpackage

// File: rtl/debounce_ctrl_sync.sv
// synchronizer: 2-flop metastability guard
// Flops are intentionally not reset
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] async_signal,
  output logic [WIDTH-1:0] sync_signal
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // two back-to-back capture stages
  always_ff @(posedge clk) begin
    s1 <= async_signal;
    s2 <= s1;
  end

  assign sync_signal = s2;

endmodule

// File: rtl/debounce_ctrl.sv
// debounce_ctrl: sync, sample, debounce, edge
// Per-channel levels plus press/release pulses
module debounce_ctrl
  import debounce_ctrl_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = SAMPLE_CNT_MAX_DEF,
  parameter int PULSE_CNT_MAX  = PULSE_CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam int SW =
    (SAMPLE_CNT_MAX > 1) ?
    $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int CW =
    $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SW-1:0] S_TOP =
    SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] C_TOP =
    CW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0]         sync;
  logic [SW-1:0]            sample_cnt;
  logic                     tick;
  logic [WIDTH-1:0][CW-1:0] sat_cnt;
  logic [WIDTH-1:0]         deb_q;

  synchronizer #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk         (clk),
    .async_signal(glitchy_signal),
    .sync_signal (sync)
  );

  assign tick = (sample_cnt == S_TOP);

  // shared sample-rate timer, wraps on tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sample_cnt <= '0;
    else if (tick)
      sample_cnt <= '0;
    else
      sample_cnt <= sample_cnt + SW'(1);
  end

  // saturating count of consecutive high samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!sync[i])
          sat_cnt[i] <= '0;
        else if (sat_cnt[i] != C_TOP)
          sat_cnt[i] <= sat_cnt[i] + CW'(1);
      end
    end
  end

  // level is high only while saturated
  always_comb begin
    debounced_signal = '0;
    for (int i = 0; i < WIDTH; i++)
      debounced_signal[i] = (sat_cnt[i] == C_TOP);
  end

  // previous level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      deb_q <= '0;
    else
      deb_q <= debounced_signal;
  end

  assign press_pulse   = debounced_signal & ~deb_q;
  assign release_pulse = ~debounced_signal & deb_q;

endmodule

// File: tb/tb_debounce_ctrl.sv
// tb_debounce_ctrl: directed vector bench
// Main DUT 4/3/2, corner DUT 1/1/1
module tb_debounce_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] g;
  logic [1:0] deb, prs, rel;
  logic       g1;
  logic       deb1, prs1, rel1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounce_ctrl #(
    .WIDTH(2),
    .SAMPLE_CNT_MAX(4),
    .PULSE_CNT_MAX(3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .glitchy_signal  (g),
    .debounced_signal(deb),
    .press_pulse     (prs),
    .release_pulse   (rel)
  );

  debounce_ctrl #(
    .WIDTH(1),
    .SAMPLE_CNT_MAX(1),
    .PULSE_CNT_MAX(1)
  ) dut1 (
    .clk             (clk),
    .rst             (rst),
    .glitchy_signal  (g1),
    .debounced_signal(deb1),
    .press_pulse     (prs1),
    .release_pulse   (rel1)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(
    input string    t,
    input int       k,
    input logic [1:0] ed,
    input logic [1:0] ep,
    input logic [1:0] er
  );
    check($sformatf("%s_deb_%0d", t, k),
          32'(deb), 32'(ed));
    check($sformatf("%s_prs_%0d", t, k),
          32'(prs), 32'(ep));
    check($sformatf("%s_rel_%0d", t, k),
          32'(rel), 32'(er));
  endtask

  task automatic reset_with(
    input logic [1:0] v
  );
    @(negedge clk);
    rst = 1'b1;
    g   = v;
    repeat (4) @(negedge clk);
    chk3("rst", 0, 2'b00, 2'b00, 2'b00);
    check("rst_deb1", 32'(deb1), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    g   = 2'b00;
    g1  = 1'b0;

    // reset hold: ch0 high through reset
    reset_with(2'b01);
    for (int k = 1; k <= 14; k++) begin
      step();
      chk3("hold", k,
           (k >= 12) ? 2'b01 : 2'b00,
           (k == 12) ? 2'b01 : 2'b00,
           2'b00);
    end

    // glitch reject then release
    reset_with(2'b00);
    g = 2'b01;
    for (int k = 1; k <= 34; k++) begin
      step();
      chk3("glr", k,
           (k >= 24 && k < 32) ? 2'b01 : 2'b00,
           (k == 24) ? 2'b01 : 2'b00,
           (k == 32) ? 2'b01 : 2'b00);
      if (k == 9)  g = 2'b00;
      if (k == 10) g = 2'b01;
      if (k == 26) g = 2'b00;
    end

    // independence and simultaneous press
    reset_with(2'b00);
    g = 2'b01;
    for (int k = 1; k <= 34; k++) begin
      logic [1:0] ed, ep, er;
      step();
      ed = 2'b00;
      ep = 2'b00;
      er = 2'b00;
      if ((k >= 12 && k < 20) || k >= 32)
        ed[0] = 1'b1;
      if (k >= 32) ed[1] = 1'b1;
      if (k == 12) ep = 2'b01;
      if (k == 32) ep = 2'b11;
      if (k == 20) er = 2'b01;
      chk3("ind", k, ed, ep, er);
      if (k == 14) g = 2'b00;
      if (k == 21) g = 2'b11;
    end

    // mid-operation asynchronous reset
    reset_with(2'b00);
    g = 2'b10;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk3("mid", k,
           (k >= 12) ? 2'b10 : 2'b00,
           (k == 12) ? 2'b10 : 2'b00,
           2'b00);
      if (k == 4) g = 2'b11;
    end
    #2;
    rst = 1'b1;
    #1;
    chk3("async", 0, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    chk3("inrst", 0, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk3("post", k,
           (k >= 12) ? 2'b11 : 2'b00,
           (k == 12) ? 2'b11 : 2'b00,
           2'b00);
    end

    // tick every cycle, single-sample press
    reset_with(2'b00);
    g1 = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      step();
      check($sformatf("sat_deb_%0d", k),
            32'(deb1),
            32'((k >= 3 && k < 53) ? 1 : 0));
      check($sformatf("sat_prs_%0d", k),
            32'(prs1),
            32'((k == 3) ? 1 : 0));
      check($sformatf("sat_rel_%0d", k),
            32'(rel1),
            32'((k == 53) ? 1 : 0));
      if (k == 50) g1 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
